// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the DPLL scan-chain controller.
package tt_scan_pkg;

  // PFD -> LPF -> divider -> lock flop scan chain length.
  localparam int unsigned DPLL_CHAIN_LEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GUARD = 2'd2,
    ST_RESP  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/tt_popcount.sv
// Combinational population count of a W-bit vector.
module tt_popcount #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/tt_scan_ctrl.sv
// Scan-chain initiator: shifts a host vector through the DPLL chain while
// capturing the old contents, then returns them with a mismatch count.
module tt_scan_ctrl
  import tt_scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DPLL_CHAIN_LEN,
  parameter int unsigned GUARD     = 2,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 i_clk_gen,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [CHAIN_LEN-1:0] i_req_wdata,
  input  logic [CHAIN_LEN-1:0] i_req_expect,
  input  logic                 i_abort,
  output logic                 o_scan_en,
  output logic                 o_scan_in,
  input  logic                 i_scan_out,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [CHAIN_LEN-1:0] o_rsp_rdata,
  output logic [CNT_W-1:0]     o_rsp_err_cnt,
  output logic                 o_busy
);

  localparam int unsigned N  = CHAIN_LEN;
  localparam int unsigned GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  scan_state_e    state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic [N-1:0]   exp_q, exp_d;
  logic [N-1:0]   cap_q, cap_d;
  logic [N-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [GW-1:0]  guard_cnt_q, guard_cnt_d;
  logic           scan_en_q, scan_en_d;
  logic           scan_in_q, scan_in_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           req_ready_q, req_ready_d;
  logic           busy_q, busy_d;

  logic           last_bit;
  logic [N-1:0]   cap_shift;
  logic [N-1:0]   cap_fin;
  logic [CNT_W-1:0] pop_cnt;

  // Capture shifts in from the top so the first (tail) sample lands in bit 0.
  assign last_bit  = (bit_cnt_q == CNT_W'(N - 1));
  assign cap_shift = {i_scan_out, cap_q[N-1:1]};
  assign cap_fin   = (state_q == ST_SHIFT) ? cap_shift : cap_q;

  tt_popcount #(
    .W  (N),
    .CW (CNT_W)
  ) u_popcount (
    .vec (cap_fin ^ exp_q),
    .cnt (pop_cnt)
  );

  always_ff @(posedge i_clk_gen or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (last_bit) begin
          state_d = (GUARD == 0) ? ST_RESP : ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (guard_cnt_q == '0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d      = data_q;
    exp_d       = exp_q;
    cap_d       = cap_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    bit_cnt_d   = bit_cnt_q;
    guard_cnt_d = guard_cnt_q;
    scan_en_d   = 1'b0;
    scan_in_d   = 1'b0;
    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          data_d    = i_req_wdata;
          exp_d     = i_req_expect;
          bit_cnt_d = '0;
          scan_en_d = 1'b1;
          scan_in_d = i_req_wdata[0];
        end
      end
      ST_SHIFT: begin
        if (!i_abort) begin
          cap_d     = cap_shift;
          data_d    = data_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (last_bit) begin
            guard_cnt_d = GW'(GUARD);
          end else begin
            scan_en_d = 1'b1;
            scan_in_d = data_q[1];
          end
        end
      end
      ST_GUARD: begin
        if (!i_abort && guard_cnt_q != '0) begin
          guard_cnt_d = guard_cnt_q - GW'(1);
        end
      end
      default: ;
    endcase

    // Response payload is frozen on the edge that enters RESP.
    if (state_d == ST_RESP && state_q != ST_RESP) begin
      rdata_d = cap_fin;
      err_d   = pop_cnt;
    end
  end

  always_ff @(posedge i_clk_gen or posedge i_rst) begin
    if (i_rst) begin
      data_q      <= '0;
      exp_q       <= '0;
      cap_q       <= '0;
      rdata_q     <= '0;
      err_q       <= '0;
      bit_cnt_q   <= '0;
      guard_cnt_q <= '0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      data_q      <= data_d;
      exp_q       <= exp_d;
      cap_q       <= cap_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      bit_cnt_q   <= bit_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      scan_en_q   <= scan_en_d;
      scan_in_q   <= scan_in_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign o_scan_en     = scan_en_q;
  assign o_scan_in     = scan_in_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_req_ready   = req_ready_q;
  assign o_busy        = busy_q;
  assign o_rsp_rdata   = rdata_q;
  assign o_rsp_err_cnt = err_q;

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Bench for tt_scan_ctrl with an 8-flop behavioural chain and a response scoreboard.
module tb_tt_scan_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_wdata;
  logic [N-1:0] req_exp;
  logic         abort;
  logic         scan_en;
  logic         scan_in;
  logic         scan_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_rdata;
  logic [CW-1:0] rsp_err;
  logic         busy;

  logic [N-1:0] chain = '0;
  logic         preload_en = 1'b0;
  logic [N-1:0] preload_val = '0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [N-1:0]  rdata;
    logic [CW-1:0] err;
  } rsp_t;

  typedef struct {
    logic [N-1:0]  wdata;
    logic [N-1:0]  exp_vec;
    logic [N-1:0]  exp_rdata;
    logic [CW-1:0] exp_err;
    int            hold;
  } vec_t;

  rsp_t sb[$];
  vec_t tbl[5];

  always #5 clk = ~clk;

  // Chain model: head is bit N-1, tail (lock flop) is bit 0.
  always @(posedge clk) begin
    if (preload_en) chain <= preload_val;
    else if (scan_en) chain <= {scan_in, chain[N-1:1]};
  end
  assign scan_out = chain[0];

  tt_scan_ctrl #(
    .CHAIN_LEN (N),
    .GUARD     (2)
  ) dut (
    .i_clk_gen     (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_wdata   (req_wdata),
    .i_req_expect  (req_exp),
    .i_abort       (abort),
    .o_scan_en     (scan_en),
    .o_scan_in     (scan_in),
    .i_scan_out    (scan_out),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_err_cnt (rsp_err),
    .o_busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scan_en"}, 32'(scan_en), 32'd0);
    check({tag, "_scan_in"}, 32'(scan_in), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic preload(input logic [N-1:0] v);
    @(negedge clk);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  // Drives req_valid for one edge; returns at the negedge after the accept edge.
  task automatic issue(input logic [N-1:0] wd, input logic [N-1:0] ev);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_wdata = wd;
    req_exp   = ev;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = ~wd;
    req_exp   = ~ev;
  endtask

  task automatic run_txn(input vec_t v);
    int lat;
    int scnt;
    logic [N-1:0] seq;
    rsp_t exp_r;
    issue(v.wdata, v.exp_vec);
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    check("busy_in_shift", 32'(busy), 32'd1);
    check("req_ready_in_shift", 32'(req_ready), 32'd0);
    lat = 0;
    scnt = 0;
    seq = '0;
    while (!rsp_valid && lat < 40) begin
      if (scan_en) begin
        seq = {scan_in, seq[N-1:1]};
        scnt++;
      end
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd11);
    check("scan_en_cycles", 32'(scnt), 32'd8);
    check("scan_in_seq", 32'(seq), 32'(v.wdata));
    check("chain_after", 32'(chain), 32'(v.wdata));
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1;
      abort     = (h == 2);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    abort     = 1'b0;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      exp_r = sb.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_rdata", 32'(rsp_rdata), 32'(exp_r.rdata));
      check("rsp_err_cnt", 32'(rsp_err), 32'(exp_r.err));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  // Abort k cycles after acceptance (k=0 is the first scan-enable cycle).
  task automatic run_abort(input int k, input logic [N-1:0] wd);
    int seen;
    issue(wd, 8'h00);
    for (int c = 0; c < k; c++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check($sformatf("abort%0d_scan_en", k), 32'(scan_en), 32'd0);
    check($sformatf("abort%0d_busy", k), 32'(busy), 32'd0);
    check($sformatf("abort%0d_req_ready", k), 32'(req_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (rsp_valid || scan_en) seen++;
      @(negedge clk);
    end
    check($sformatf("abort%0d_no_rsp", k), 32'(seen), 32'd0);
  endtask

  initial begin
    tbl[0] = '{wdata: 8'hA5, exp_vec: 8'h00, exp_rdata: 8'h00, exp_err: 4'd0, hold: 0};
    tbl[1] = '{wdata: 8'h3C, exp_vec: 8'hA5, exp_rdata: 8'hA5, exp_err: 4'd0, hold: 0};
    tbl[2] = '{wdata: 8'h5A, exp_vec: 8'hFF, exp_rdata: 8'h3C, exp_err: 4'd4, hold: 5};
    tbl[3] = '{wdata: 8'hFF, exp_vec: 8'h00, exp_rdata: 8'h5A, exp_err: 4'd4, hold: 0};
    tbl[4] = '{wdata: 8'h00, exp_vec: 8'h00, exp_rdata: 8'hFF, exp_err: 4'd8, hold: 1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_wdata = '0;
    req_exp   = '0;
    abort     = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    req_valid = 1'b1;
    req_wdata = 8'hA5;
    @(negedge clk);
    check("req_in_reset_busy", 32'(busy), 32'd0);
    check("req_in_reset_scan_en", 32'(scan_en), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    preload(8'h00);
    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    run_abort(4, 8'hC3);
    run_abort(7, 8'h81);
    run_abort(9, 8'h7E);

    // Reset pulsed mid-shift must drop scan enable before the next edge.
    preload(8'h66);
    issue(8'h99, 8'h66);
    repeat (3) @(negedge clk);
    check("pre_rst_scan_en", 32'(scan_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    req_valid = 1'b1;
    @(negedge clk);
    check("req_in_midrst_busy", 32'(busy), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    preload(8'h66);
    run_txn('{wdata: 8'h99, exp_vec: 8'h6E, exp_rdata: 8'h66, exp_err: 4'd1, hold: 0});

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
